// File: rtl/mux_8to1_nand_tree.sv
// 8:1 single-bit mux built only from NAND gates: two 4:1 NAND muxes feed a
// 2:1 NAND mux steered by s2. y is combinational; y_q is y registered once.

// Generic N-input NAND; inverters are this cell with inputs tied together.
module mux_8to1_nand_tree_nand #(
  parameter int N = 2
) (
  input  logic [N-1:0] a_i,
  output logic         y_o
);
  assign y_o = ~(&a_i);
endmodule

// 4:1 mux: decode complemented selects, gate each data bit with its
// select minterm in a NAND3, then merge the four terms with a NAND4.
module mux_8to1_nand_tree_mux4 (
  input  logic [3:0] d_i,
  input  logic       s1_i,
  input  logic       s0_i,
  output logic       y_o
);
  logic       s1_n, s0_n;
  logic [3:0] sel1, sel0;
  logic [3:0] term;

  mux_8to1_nand_tree_nand #(.N(2)) u_inv_s1 (.a_i({s1_i, s1_i}), .y_o(s1_n));
  mux_8to1_nand_tree_nand #(.N(2)) u_inv_s0 (.a_i({s0_i, s0_i}), .y_o(s0_n));

  // Minterm k uses true or complemented select bits according to k.
  assign sel1 = {s1_i, s1_i, s1_n, s1_n};
  assign sel0 = {s0_i, s0_n, s0_i, s0_n};

  for (genvar k = 0; k < 4; k++) begin : g_term
    mux_8to1_nand_tree_nand #(.N(3)) u_term (
      .a_i({d_i[k], sel1[k], sel0[k]}),
      .y_o(term[k])
    );
  end

  mux_8to1_nand_tree_nand #(.N(4)) u_out (.a_i(term), .y_o(y_o));
endmodule

// 2:1 mux: y = NAND(NAND(lo, s_n), NAND(hi, s)).
module mux_8to1_nand_tree_mux2 (
  input  logic lo_i,
  input  logic hi_i,
  input  logic s_i,
  output logic y_o
);
  logic s_n, t_lo, t_hi;

  mux_8to1_nand_tree_nand #(.N(2)) u_inv  (.a_i({s_i, s_i}),   .y_o(s_n));
  mux_8to1_nand_tree_nand #(.N(2)) u_lo   (.a_i({lo_i, s_n}),  .y_o(t_lo));
  mux_8to1_nand_tree_nand #(.N(2)) u_hi   (.a_i({hi_i, s_i}),  .y_o(t_hi));
  mux_8to1_nand_tree_nand #(.N(2)) u_out  (.a_i({t_lo, t_hi}), .y_o(y_o));
endmodule

module mux_8to1_nand_tree (
  input  logic clk,
  input  logic rst,
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic i4,
  input  logic i5,
  input  logic i6,
  input  logic i7,
  input  logic s0,
  input  logic s1,
  input  logic s2,
  output logic y,
  output logic y_q
);
  logic lo, hi;
  logic y_d;

  // Lower half i0-i3, upper half i4-i7, both on s1/s0.
  mux_8to1_nand_tree_mux4 u_lo (
    .d_i ({i3, i2, i1, i0}),
    .s1_i(s1),
    .s0_i(s0),
    .y_o (lo)
  );

  mux_8to1_nand_tree_mux4 u_hi (
    .d_i ({i7, i6, i5, i4}),
    .s1_i(s1),
    .s0_i(s0),
    .y_o (hi)
  );

  // Final stage picks the half with s2.
  mux_8to1_nand_tree_mux2 u_fin (
    .lo_i(lo),
    .hi_i(hi),
    .s_i (s2),
    .y_o (y)
  );

  assign y_d = y;

  // Register the mux output; synchronous reset clears it.
  always_ff @(posedge clk) begin
    if (rst) y_q <= 1'b0;
    else     y_q <= y_d;
  end
endmodule

// File: tb/tb_mux_8to1_nand_tree.sv
// Directed bench for mux_8to1_nand_tree: sweep, walking 1/0, register
// latency, reset, and an exhaustive combinational check.
module tb_mux_8to1_nand_tree;
  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic [2:0] sel;
  logic       y, y_q;

  int total = 0;
  int bad   = 0;

  mux_8to1_nand_tree dut (
    .clk(clk), .rst(rst),
    .i0(din[0]), .i1(din[1]), .i2(din[2]), .i3(din[3]),
    .i4(din[4]), .i5(din[5]), .i6(din[6]), .i7(din[7]),
    .s0(sel[0]), .s1(sel[1]), .s2(sel[2]),
    .y(y), .y_q(y_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; din = 8'hFF; sel = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (y_q !== 1'b0) begin
      bad++; $display("FAIL reset_yq got=%b want=0", y_q);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // i0..i7 = 0,1,0,1,1,0,1,0
  task automatic test_sweep();
    logic exp_y [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    din = 8'b0101_1010;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      #10;
      total++;
      if (y !== exp_y[s]) begin
        bad++; $display("FAIL sweep sel=%0d got=%b want=%b", s, y, exp_y[s]);
      end
    end
  endtask

  task automatic test_walk_one();
    for (int k = 0; k < 8; k++) begin
      din = 8'h00;
      din[k] = 1'b1;
      for (int s = 0; s < 8; s++) begin
        sel = 3'(s);
        #1;
        total++;
        if (y !== (s == k)) begin
          bad++; $display("FAIL walk1 k=%0d sel=%0d got=%b want=%b", k, s, y, (s == k));
        end
      end
    end
  endtask

  task automatic test_walk_zero();
    for (int k = 0; k < 8; k++) begin
      din = 8'hFF;
      din[k] = 1'b0;
      for (int s = 0; s < 8; s++) begin
        sel = 3'(s);
        #1;
        total++;
        if (y !== (s != k)) begin
          bad++; $display("FAIL walk0 k=%0d sel=%0d got=%b want=%b", k, s, y, (s != k));
        end
      end
    end
  endtask

  // sel=3, i3 toggles each cycle; y_q must show the value present before the edge.
  task automatic test_latency();
    logic prev;
    @(negedge clk);
    rst = 1'b0; sel = 3'b011; din = 8'b0000_1000;
    for (int c = 0; c < 8; c++) begin
      #1 prev = din[3];
      @(posedge clk);
      #1;
      total++;
      if (y_q !== prev) begin
        bad++; $display("FAIL latency cyc=%0d got=%b want=%b", c, y_q, prev);
      end
      @(negedge clk);
      din[3] = ~din[3];
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    sel = 3'b110; din = 8'b0100_0000;   // y = 1
    @(posedge clk); #1;
    total++;
    if (y_q !== 1'b1) begin
      bad++; $display("FAIL pre_reset_yq got=%b want=1", y_q);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      total++;
      if (y_q !== 1'b0) begin
        bad++; $display("FAIL midrst_yq edge=%0d got=%b want=0", c, y_q);
      end
      total++;
      if (y !== 1'b1) begin
        bad++; $display("FAIL midrst_y edge=%0d got=%b want=1", c, y);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (y_q !== 1'b1) begin
      bad++; $display("FAIL release_yq got=%b want=1", y_q);
    end
  endtask

  task automatic test_exhaustive();
    logic [10:0] v;
    logic        exp;
    for (int n = 0; n < 2048; n++) begin
      v   = 11'(n);
      din = v[7:0];
      sel = v[10:8];
      #1;
      exp = v[int'(v[10:8])];
      total++;
      if (y !== exp) begin
        bad++; $display("FAIL exhaustive vec=%h got=%b want=%b", v, y, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; din = 8'h00; sel = 3'd0;
    test_reset();
    test_sweep();
    test_walk_one();
    test_walk_zero();
    test_latency();
    test_mid_reset();
    test_exhaustive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
